picorv_mem_bridge: RTL and testbench

Memory-bus bridge between the picorv32 native memory interface and the shared main-memory port A plus a small MMIO register file. It decodes each core request into main RAM, MMIO, or unmapped space, absorbs the BRAM read latency, and performs read-modify-write for partial-word stores. The block replaces ad-hoc memory sequencing next to the core and gives software LEDs, switches, a cycle counter and a bus-error flag.

---
 rtl/mem_map_pkg.sv | 35 +++
 rtl/mmio_regs.sv | 80 ++++++++
 rtl/picorv_mem_bridge.sv | 160 ++++++++++++++++
 tb/tb_picorv_mem_bridge.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
//==============================================================================
// Module : mem_map_pkg
// Brief  : Shared MMIO offsets, bridge state type and strobe-mask helper.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package mem_map_pkg;

    // Word offsets inside the 16-byte MMIO window (mem_addr[3:2])
    localparam logic [1:0] c_off_led    = 2'd0;
    localparam logic [1:0] c_off_sw     = 2'd1;
    localparam logic [1:0] c_off_cycles = 2'd2;
    localparam logic [1:0] c_off_status = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RMW_WAIT = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RESP     = 3'd4
    } bridge_state_e;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_regs.sv
//==============================================================================
// Module : mmio_regs
// Brief  : LED, synchronised switches, free-running cycle counter and status.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module mmio_regs
    import mem_map_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        set_err_i,
    input  logic [15:0] sw_i,
    output logic [31:0] rdata_o,
    output logic [15:0] led_o,
    output logic        bus_error_o
);

    logic [15:0] sw_meta_q;
    logic [15:0] sw_sync_q;
    logic [15:0] led_q;
    logic [31:0] cycles_q;
    logic        err_q;

    logic w_unused_wdata;
    assign w_unused_wdata = ^{wdata_i[31:16], wstrb_i[3:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            led_q     <= '0;
            cycles_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            sw_meta_q <= sw_i;
            sw_sync_q <= sw_meta_q;

            // A clear write takes priority over the increment
            if (wr_en_i && (offset_i == c_off_cycles)) begin
                cycles_q <= '0;
            end else begin
                cycles_q <= cycles_q + 32'd1;
            end

            if (wr_en_i && (offset_i == c_off_led)) begin
                if (wstrb_i[0]) led_q[7:0]  <= wdata_i[7:0];
                if (wstrb_i[1]) led_q[15:8] <= wdata_i[15:8];
            end

            if (set_err_i) begin
                err_q <= 1'b1;
            end else if (wr_en_i && (offset_i == c_off_status) && wstrb_i[0] && wdata_i[0]) begin
                err_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        case (offset_i)
            c_off_led:    rdata_o = {16'h0000, led_q};
            c_off_sw:     rdata_o = {16'h0000, sw_sync_q};
            c_off_cycles: rdata_o = cycles_q;
            c_off_status: rdata_o = {31'd0, err_q};
            default:      rdata_o = '0;
        endcase
    end

    assign led_o       = led_q;
    assign bus_error_o = err_q;

endmodule

`default_nettype wire

// File: rtl/picorv_mem_bridge.sv
//==============================================================================
// Module : picorv_mem_bridge
// Brief  : picorv32 native bus to BRAM port A plus MMIO, with RMW for partial stores.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module picorv_mem_bridge
    import mem_map_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          RAM_LATENCY = 2,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    output logic                  ram_we,
    input  logic [31:0]           ram_dout,
    input  logic [15:0]           sw,
    output logic [15:0]           led,
    output logic                  bus_error
);

    localparam logic [7:0] c_lat_last = 8'(RAM_LATENCY);

    bridge_state_e         state_q;
    logic [7:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [31:0]           ram_din_q;
    logic                  ram_we_q;
    logic                  mem_ready_q;
    logic [31:0]           mem_rdata_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;

    logic        w_is_ram;
    logic        w_is_mmio;
    logic        w_accept;
    logic        w_mmio_wr;
    logic        w_set_err;
    logic [31:0] w_mmio_rdata;
    logic [31:0] w_mask;

    logic w_unused;
    assign w_unused = mem_instr;

    assign w_is_ram  = (mem_addr >> (ADDR_WIDTH + 2)) == 32'd0;
    assign w_is_mmio = !w_is_ram && (mem_addr[31:4] == MMIO_BASE[31:4]);
    assign w_accept  = (state_q == ST_IDLE) && mem_valid;
    assign w_mmio_wr = w_accept && w_is_mmio && (mem_wstrb != 4'h0);
    assign w_set_err = w_accept && !w_is_ram && !w_is_mmio;
    assign w_mask    = strb_to_mask(wstrb_q);

    mmio_regs u_mmio_regs (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (w_mmio_wr),
        .offset_i    (mem_addr[3:2]),
        .wdata_i     (mem_wdata),
        .wstrb_i     (mem_wstrb),
        .set_err_i   (w_set_err),
        .sw_i        (sw),
        .rdata_o     (w_mmio_rdata),
        .led_o       (led),
        .bus_error_o (bus_error)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_we_q    <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            ram_we_q    <= 1'b0;
            mem_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    mem_rdata_q <= '0;
                    if (mem_valid) begin
                        ram_addr_q <= mem_addr[ADDR_WIDTH+1:2];
                        wdata_q    <= mem_wdata;
                        wstrb_q    <= mem_wstrb;
                        cnt_q      <= '0;
                        if (w_is_ram) begin
                            if (mem_wstrb == 4'h0) begin
                                state_q <= ST_RD_WAIT;
                            end else if (mem_wstrb == 4'hF) begin
                                ram_din_q <= mem_wdata;
                                ram_we_q  <= 1'b1;
                                state_q   <= ST_WRITE;
                            end else begin
                                state_q <= ST_RMW_WAIT;
                            end
                        end else begin
                            // MMIO and unmapped both answer in one cycle
                            mem_ready_q <= 1'b1;
                            state_q     <= ST_RESP;
                            if (w_is_mmio && (mem_wstrb == 4'h0)) begin
                                mem_rdata_q <= w_mmio_rdata;
                            end
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt_q == c_lat_last) begin
                        mem_rdata_q <= ram_dout;
                        mem_ready_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RMW_WAIT: begin
                    if (cnt_q == c_lat_last) begin
                        ram_din_q <= (ram_dout & ~w_mask) | (wdata_q & w_mask);
                        ram_we_q  <= 1'b1;
                        state_q   <= ST_WRITE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_WRITE: begin
                    mem_ready_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    mem_rdata_q <= '0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_we    = ram_we_q;

endmodule

`default_nettype wire

// File: tb/tb_picorv_mem_bridge.sv
//==============================================================================
// Module : tb_picorv_mem_bridge
// Brief  : Directed self-checking bench for picorv_mem_bridge with a BRAM model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_picorv_mem_bridge;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [11:0] ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;
    logic [15:0] sw;
    logic [15:0] led;
    logic        bus_error;

    logic [31:0] ram_mem [0:4095];
    logic [31:0] ram_pipe;
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;

    int passed;
    int total;

    picorv_mem_bridge #(
        .ADDR_WIDTH  (12),
        .RAM_LATENCY (2),
        .MMIO_BASE   (32'h8000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .sw        (sw),
        .led       (led),
        .bus_error (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage BRAM: address sampled at edge k, data visible after edge k+1
    always @(posedge clk) begin
        if (pre_we) ram_mem[pre_addr] <= pre_data;
        else if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_pipe <= ram_mem[ram_addr];
        ram_dout <= ram_pipe;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issues one request; lat is the edge at which mem_ready is sampled (-1 on timeout)
    task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int lat, output logic [31:0] rdata, output int we_cnt,
                           output int we_edge, output logic [31:0] we_din, output int pulse_ok);
        lat = -1; rdata = '0; we_cnt = 0; we_edge = -1; we_din = '0; pulse_ok = 0;
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (ram_we) begin we_cnt++; we_edge = e; we_din = ram_din; end
            if (mem_ready) begin lat = e + 1; rdata = mem_rdata; break; end
        end
        mem_valid = 1'b0;
        @(posedge clk); #1;
        if (ram_we) we_cnt++;
        pulse_ok = (mem_ready == 1'b0) ? 1 : 0;
    endtask

    initial begin
        int lat, we_cnt, we_edge, pulse_ok, we_seen;
        logic [31:0] rd, din;
        passed = 0; total = 0;
        rst_n = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0;
        mem_wdata = '0; mem_wstrb = '0; sw = 16'h00F0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        preload(12'h010, 32'hDEAD_BEEF);
        preload(12'h020, 32'h1122_3344);
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
        check("rst_ram_din", ram_din, 32'd0);
        check("rst_led", {16'd0, led}, 32'd0);
        check("rst_bus_error", {31'd0, bus_error}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_req(32'h0000_0040, 32'h0, 4'h0, lat, rd, we_cnt, we_edge, din, pulse_ok);
        check("rd_latency", 32'(lat), 32'd4);
        check("rd_data", rd, 32'hDEAD_BEEF);
        check("rd_pulse_one_cycle", 32'(pulse_ok), 32'd1);
        check("rd_no_we", 32'(we_cnt), 32'd0);

        run_req(32'h0000_0080, 32'h0000_00AA, 4'b0001, lat, rd, we_cnt, we_edge, din, pulse_ok);
        check("rmw_latency", 32'(lat), 32'd5);
        check("rmw_we_count", 32'(we_cnt), 32'd1);
        check("rmw_din", din, 32'h1122_33AA);
        check("rmw_rdata_zero", rd, 32'd0);
        run_req(32'h0000_0080, 32'h0, 4'h0, lat, rd, we_cnt, we_edge, din, pulse_ok);
        check("rmw_readback", rd, 32'h1122_33AA);

        run_req(32'h0000_0084, 32'hCAFE_F00D, 4'hF, lat, rd, we_cnt, we_edge, din, pulse_ok);
        check("full_latency", 32'(lat), 32'd2);
        check("full_we_count", 32'(we_cnt), 32'd1);
        check("full_we_edge", 32'(we_edge), 32'd0);
        check("full_din", din, 32'hCAFE_F00D);
        run_req(32'h0000_0084, 32'h0, 4'h0, lat, rd, we_cnt, we_edge, din, pulse_ok);
        check("full_readback", rd, 32'hCAFE_F00D);

        run_req(32'h8000_0000, 32'h0000_5A5A, 4'hF, lat, rd, we_cnt, we_edge, din, pulse_ok);
        check("led_wr_latency", 32'(lat), 32'd1);
        check("led_value", {16'd0, led}, 32'h0000_5A5A);
        check("mmio_wr_no_ram_we", 32'(we_cnt), 32'd0);
        run_req(32'h8000_0000, 32'hFFFF_12FF, 4'b0010, lat, rd, we_cnt, we_edge, din, pulse_ok);
        check("led_byte1_only", {16'd0, led}, 32'h0000_125A);
        run_req(32'h8000_0000, 32'h0, 4'h0, lat, rd, we_cnt, we_edge, din, pulse_ok);
        check("led_readback", rd, 32'h0000_125A);

        run_req(32'h8000_0004, 32'h0, 4'h0, lat, rd, we_cnt, we_edge, din, pulse_ok);
        check("sw_read", rd, 32'h0000_00F0);
        check("sw_latency", 32'(lat), 32'd1);

        run_req(32'h8000_0008, 32'h0, 4'hF, lat, rd, we_cnt, we_edge, din, pulse_ok);
        run_req(32'h8000_0008, 32'h0, 4'h0, lat, rd, we_cnt, we_edge, din, pulse_ok);
        check("cycles_small", {31'd0, rd <= 32'd3}, 32'd1);

        run_req(32'h4000_0000, 32'h0, 4'h0, lat, rd, we_cnt, we_edge, din, pulse_ok);
        check("unmapped_latency", 32'(lat), 32'd1);
        check("unmapped_rdata", rd, 32'd0);
        check("unmapped_bus_error", {31'd0, bus_error}, 32'd1);
        run_req(32'h8000_000C, 32'h0, 4'h0, lat, rd, we_cnt, we_edge, din, pulse_ok);
        check("status_read", rd, 32'd1);
        run_req(32'h8000_000C, 32'h1, 4'hF, lat, rd, we_cnt, we_edge, din, pulse_ok);
        check("status_clear", {31'd0, bus_error}, 32'd0);

        // First byte past RAM is unmapped: write must be dropped
        run_req(32'h0000_4000, 32'h1234_5678, 4'hF, lat, rd, we_cnt, we_edge, din, pulse_ok);
        check("ram_top_drop_we", 32'(we_cnt), 32'd0);
        check("ram_top_latency", 32'(lat), 32'd1);
        check("ram_top_bus_error", {31'd0, bus_error}, 32'd1);

        // Abort a partial store while it waits on the RAM read
        mem_valid = 1'b1; mem_addr = 32'h0000_0088; mem_wdata = 32'h55; mem_wstrb = 4'b0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        mem_valid = 1'b0;
        #1;
        we_seen = 0;
        check("abort_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("abort_led", {16'd0, led}, 32'd0);
        check("abort_bus_error", {31'd0, bus_error}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ram_we || mem_ready) we_seen++;
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ram_we || mem_ready) we_seen++;
        end
        check("abort_no_leak", 32'(we_seen), 32'd0);

        run_req(32'h0000_0040, 32'h0, 4'h0, lat, rd, we_cnt, we_edge, din, pulse_ok);
        check("post_rst_rd_latency", 32'(lat), 32'd4);
        check("post_rst_rd_data", rd, 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
